mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all address buses.
REQ-002 SHALL have parameter DATA_W, default 32, width of all data buses.
REQ-003 SHALL have parameter STARVE_MAX, default 3, max consecutive data grants while fetch waits.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have fetch ports if_req in 1, if_addr in ADDR_W, if_gnt out 1, if_rvalid out 1, if_rdata out DATA_W.
REQ-007 SHALL have data ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_gnt out 1, d_rvalid out 1, d_rdata out DATA_W.
REQ-008 SHALL have memory ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_ready in 1, mem_rdata in DATA_W.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-011 IDLE: no req -> stay IDLE; any req -> select winner, latch addr/we/wdata into mem_*, go ACCESS.
REQ-012 Winner: d_req beats if_req, except when starvation rule (REQ-019) forces fetch.
REQ-013 First ACCESS cycle: winner gnt high exactly one cycle; mem_req high from first ACCESS cycle until cycle mem_ready sampled high.
REQ-014 Fetch grant: mem_we=0; data grant: mem_we=d_we, mem_wdata=d_wdata.
REQ-015 ACCESS + mem_ready=1 -> capture mem_rdata, go RESP; mem_req low in RESP; mem_* addr/data held stable throughout ACCESS.
REQ-016 RESP: owner rvalid high one cycle with rdata = captured mem_rdata; writes also pulse d_rvalid (completion) with d_rdata = captured value; go IDLE next cycle.
REQ-017 Minimum transaction = 4 cycles req-to-IDLE (IDLE, ACCESS with same-cycle mem_ready, RESP, IDLE); requester holds req/addr/wdata until gnt.
REQ-018 mem_ready in IDLE or RESP SHALL be ignored; req inputs ignored outside IDLE.
REQ-019 Starvation counter (2-bit min, sized for STARVE_MAX): +1 on data grant while if_req high; when equal STARVE_MAX and if_req high in IDLE, fetch wins; cleared on fetch grant or IDLE with if_req low.
REQ-020 Never both gnt or both rvalid in same cycle; rdata outputs hold last value when rvalid low.

Reset
REQ-021 rst high at clock edge SHALL force IDLE, counter 0, all outputs 0 (gnt, rvalid, mem_req, mem_we, mem_addr, mem_wdata, rdata, busy).
REQ-022 Reset mid-ACCESS/RESP SHALL abandon transaction: no rvalid for it after reset, mem_req low next cycle.

Configuration
REQ-023 Macro MEM_ARB_STARVE_GUARD_EN defined: REQ-019 active.
REQ-024 Macro undefined: counter not built, strict data priority, fetch granted only when d_req low in IDLE.

Verification
REQ-025 Single fetch: if_req=1, if_addr=0x40, mem_ready high first ACCESS cycle, mem_rdata=0xDEADBEEF -> if_gnt cycle 1, if_rvalid cycle 2 with 0xDEADBEEF, busy low cycle 3.
REQ-026 Simultaneous: if_req=d_req=1, d_addr=0x100, d_we=1, d_wdata=0x55 -> d_gnt first, mem_we=1, mem_wdata=0x55; if_gnt only after d_rvalid.
REQ-027 Wait states: mem_ready low 5 ACCESS cycles -> mem_req held high, mem_addr stable 6 cycles, one rvalid after.
REQ-028 Starvation (macro on, STARVE_MAX=3): both reqs held high continuously -> grant order D,D,D,I,D,D,D,I; macro off -> only D grants.
REQ-029 Reset mid-ACCESS: rst pulsed 1 cycle during ACCESS with mem_ready=1 same edge -> no rvalid, all outputs 0, next req arbitrated from IDLE.
REQ-030 Spurious mem_ready=1 in IDLE with no req -> no state change, no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Two-port (fetch/data) arbiter onto a single ready-handshaked
//            memory port. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;   // 1: data port owns the access
    logic                if_gnt_q, if_gnt_d;
    logic                d_gnt_q, d_gnt_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;
    logic                w_pick_data;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int c_CNT_W = ($clog2(STARVE_MAX + 1) > 2) ? $clog2(STARVE_MAX + 1) : 2;
    localparam logic [c_CNT_W-1:0] c_STARVE_LIM = c_CNT_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic               w_force_fetch;

    assign w_force_fetch = if_req && (starve_cnt_q == c_STARVE_LIM);
    assign w_pick_data   = d_req && !w_force_fetch;

    // Counts data wins that overtook a waiting fetch; only moves on IDLE decisions.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (!if_req) begin
                starve_cnt_d = '0;
            end else if (w_pick_data) begin
                if (starve_cnt_q != c_STARVE_LIM) begin
                    starve_cnt_d = starve_cnt_q + c_CNT_W'(1);
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign w_pick_data = d_req;

    // STARVE_MAX has no effect when the guard is not built.
    if (STARVE_MAX < 0) begin : g_starve_max_unused
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (if_req || d_req) begin
                    state_d   = ACCESS;
                    mem_req_d = 1'b1;
                    if (w_pick_data) begin
                        owner_d     = 1'b1;
                        d_gnt_d     = 1'b1;
                        mem_addr_d  = d_addr;
                        mem_we_d    = d_we;
                        mem_wdata_d = d_wdata;
                    end else begin
                        owner_d     = 1'b0;
                        if_gnt_d    = 1'b1;
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter with a wait-state memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, d_req, d_we;
    logic [ADDR_W-1:0] if_addr, d_addr, mem_addr;
    logic [DATA_W-1:0] d_wdata, mem_wdata, mem_rdata, if_rdata, d_rdata;
    logic              if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic              mem_req, mem_we, mem_ready, busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(3)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    typedef struct packed {
        logic        port;   // 1: data port
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } resp_t;

    gnt_t  gnt_q[$];
    resp_t resp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    wait_cfg = 0;
    int    wait_cnt = 0;
    bit    force_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_for(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Memory model: ready after wait_cfg stalled ACCESS cycles.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wait_cnt >= wait_cfg) begin
                mem_ready = 1'b1;
                mem_rdata = data_for(mem_addr);
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            wait_cnt  = 0;
            mem_ready = force_ready;
            mem_rdata = force_ready ? 32'hBAD0_0000 : 32'h0;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        gnt_t  g;
        resp_t r;
        if (if_gnt || d_gnt) begin
            chk("dual_gnt", {63'd0, if_gnt & d_gnt}, 64'd0);
            chk("gnt_mem_req", {63'd0, mem_req}, 64'd1);
            if (gnt_q.size() == 0) begin
                chk("unexpected_gnt", 64'd1, 64'd0);
            end else begin
                g = gnt_q.pop_front();
                chk("gnt_port", {63'd0, d_gnt}, {63'd0, g.port});
                chk("gnt_addr", {32'd0, mem_addr}, {32'd0, g.addr});
                chk("gnt_we", {63'd0, mem_we}, {63'd0, g.we});
                if (g.we) chk("gnt_wdata", {32'd0, mem_wdata}, {32'd0, g.wdata});
            end
        end
        if (if_rvalid || d_rvalid) begin
            chk("dual_rvalid", {63'd0, if_rvalid & d_rvalid}, 64'd0);
            if (resp_q.size() == 0) begin
                chk("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                r = resp_q.pop_front();
                chk("resp_port", {63'd0, d_rvalid}, {63'd0, r.port});
                chk("resp_data", {32'd0, d_rvalid ? d_rdata : if_rdata}, {32'd0, r.data});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input logic port, input logic [31:0] a, input logic we,
                            input logic [31:0] wd);
        gnt_t  g;
        resp_t r;
        g.port = port; g.addr = a; g.we = we; g.wdata = wd;
        r.port = port; r.data = data_for(a);
        gnt_q.push_back(g);
        resp_q.push_back(r);
    endtask

    task automatic serve(input int max_cycles);
        int n = 0;
        do begin
            tick();
            if (if_gnt) if_req = 1'b0;
            if (d_gnt)  d_req  = 1'b0;
            n++;
        end while (!(!if_req && !d_req && !busy && resp_q.size() == 0) && n < max_cycles);
        chk("serve_done", {63'd0, (!if_req && !d_req && !busy && resp_q.size() == 0)}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   k, cnt, dr_cyc, ig_cyc;
        bit   stable;
        gnt_t g;
        logic [7:0] order;

        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_gnts", {62'd0, if_gnt, d_gnt}, 64'd0);
        chk("rst_rvalids", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        chk("rst_mem_bus", {31'd0, mem_we, mem_addr}, 64'd0);
        rst = 1'b0;
        tick();

        // Spurious ready while idle
        force_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("spur_busy", {63'd0, busy}, 64'd0);
            chk("spur_mem_req", {63'd0, mem_req}, 64'd0);
        end
        force_ready = 1'b0;
        tick();

        // Single fetch, cycle-exact
        if_req = 1'b1; if_addr = 32'h40;
        push_txn(1'b0, 32'h40, 1'b0, 32'h0);
        tick();
        chk("f_if_gnt_c1", {63'd0, if_gnt}, 64'd1);
        chk("f_busy_c1", {63'd0, busy}, 64'd1);
        if_req = 1'b0;
        tick();
        chk("f_if_rvalid_c2", {63'd0, if_rvalid}, 64'd1);
        chk("f_if_rdata_c2", {32'd0, if_rdata}, 64'hDEADBEEF);
        tick();
        chk("f_busy_c3", {63'd0, busy}, 64'd0);
        chk("f_rvalid_c3", {63'd0, if_rvalid}, 64'd0);
        chk("f_rdata_hold", {32'd0, if_rdata}, 64'hDEADBEEF);

        // Simultaneous requests: data first, fetch after data completes
        if_req = 1'b1; if_addr = 32'h44;
        d_req = 1'b1; d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'h55;
        push_txn(1'b1, 32'h100, 1'b1, 32'h55);
        push_txn(1'b0, 32'h44, 1'b0, 32'h0);
        dr_cyc = -1; ig_cyc = -1; k = 0;
        do begin
            tick();
            if (d_rvalid && dr_cyc < 0) dr_cyc = k;
            if (if_gnt && ig_cyc < 0) ig_cyc = k;
            if (if_gnt) if_req = 1'b0;
            if (d_gnt)  d_req  = 1'b0;
            k++;
        end while ((if_req || d_req || busy || resp_q.size() != 0) && k < 40);
        chk("sim_fetch_after_drvalid", {63'd0, (dr_cyc >= 0 && ig_cyc > dr_cyc)}, 64'd1);
        d_we = 1'b0;

        // Wait states
        wait_cfg = 5;
        d_req = 1'b1; d_addr = 32'h180; d_we = 1'b0; d_wdata = '0;
        push_txn(1'b1, 32'h180, 1'b0, 32'h0);
        tick();
        chk("ws_d_gnt", {63'd0, d_gnt}, 64'd1);
        d_req = 1'b0;
        cnt = 0; stable = 1'b1;
        while (mem_req && cnt < 20) begin
            if (mem_addr !== 32'h180) stable = 1'b0;
            cnt++;
            tick();
        end
        chk("ws_req_cycles", cnt, 64'd6);
        chk("ws_addr_stable", {63'd0, stable}, 64'd1);
        chk("ws_rvalid", {63'd0, d_rvalid}, 64'd1);
        serve(20);
        wait_cfg = 0;

        // Reset during ACCESS, coinciding with mem_ready
        if_req = 1'b1; if_addr = 32'h80;
        g.port = 1'b0; g.addr = 32'h80; g.we = 1'b0; g.wdata = '0;
        gnt_q.push_back(g);
        tick();
        chk("rst_mid_gnt", {63'd0, if_gnt}, 64'd1);
        if_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        chk("rst_mid_if_rdata", {32'd0, if_rdata}, 64'd0);
        chk("rst_mid_d_rdata", {32'd0, d_rdata}, 64'd0);
        chk("rst_mid_mem_bus", {31'd0, mem_we, mem_addr}, 64'd0);
        repeat (4) tick();
        d_req = 1'b1; d_addr = 32'h1C0; d_we = 1'b1; d_wdata = 32'hA5;
        push_txn(1'b1, 32'h1C0, 1'b1, 32'hA5);
        serve(20);
        d_we = 1'b0;

        // Both requests held: starvation pattern
`ifdef MEM_ARB_STARVE_GUARD_EN
        order = 8'b1110_1110;
`else
        order = 8'b1111_1111;
`endif
        for (int i = 7; i >= 0; i--) begin
            if (order[i]) push_txn(1'b1, 32'h300, 1'b0, 32'h0);
            else          push_txn(1'b0, 32'h200, 1'b0, 32'h0);
        end
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_addr = 32'h300;
        k = 0; cnt = 0;
        while (k < 8 && cnt < 100) begin
            tick();
            if (if_gnt || d_gnt) k++;
            cnt++;
        end
        chk("starve_grants", k, 64'd8);
        if_req = 1'b0; d_req = 1'b0;
        serve(20);

        chk("gnt_q_empty", gnt_q.size(), 64'd0);
        chk("resp_q_empty", resp_q.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
